psg_bus_decoder: RTL and testbench
==================================

# psg_bus_decoder

Host-side register interface for the AY-3-8910-compatible PSG. It decodes the BDIR/BC1 bus protocol, latches register addresses and commits register writes. It holds the 16-entry register file and drives the width-masked control fields consumed by the tone, noise, mixer and envelope blocks. It is the writer end of the `period` input that the noise generator reads.

## Interface
Parameters:
- CHIP_ADDR, 4'h0: upper-nibble chip select. An address latch is accepted only if data_in[7:4] == CHIP_ADDR.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- bdir  in  1  bus direction (AY BDIR)
- bc1  in  1  bus control (AY BC1)
- data_in  in  8  host data / address bus
- data_out  out  8  read data (masked register value)
- data_oe  out  1  read drive enable
- tone_period_a/b/c  out  12 each  {R1[3:0],R0} / {R3[3:0],R2} / {R5[3:0],R4}
- noise_period  out  5  R6[4:0]
- mixer  out  8  R7 (active-low enables, as on the AY)
- amp_a/b/c  out  5 each  R8/R9/R10 [4:0]
- env_period  out  16  {R12,R11}
- env_shape  out  4  R13[3:0]
- env_restart  out  1  one-cycle pulse on every R13 write
- io_a, io_b  out  8 each  R14, R15

## Operation
- Bus inputs {bdir,bc1,data_in} are registered once (sample stage). All decoding uses the sampled values. Sampled mode: 00 inactive, 01 read, 10 write, 11 latch address.
- Latch (11): if data_in[7:4]==CHIP_ADDR, then addr <= data_in[3:0] and addr_valid <= 1; otherwise addr_valid <= 0. Latching repeats every cycle the mode is held. The last sampled value wins.
- Write (10): hold_data <= data_in every cycle while in write mode. The commit happens on the first sampled cycle whose mode != 10 following a cycle with mode == 10. On commit, if addr_valid, reg[addr] <= hold_data masked to the register width. Widths: R1,R3,R5,R13 = 4 bits; R6,R8,R9,R10 = 5 bits; all others 8 bits. Unused bits are stored as 0.
- Write with addr_valid == 0: the data is discarded and no register changes.
- Commit to address 13 raises env_restart for exactly one cycle, including when the value written equals the stored value.
- Read (01): if addr_valid, data_oe = 1 and data_out = reg[addr] with unused bits 0. If not addr_valid, data_oe = 0 and data_out = 0.
- Direct 10 -> 11 transition: the commit uses the old addr. The new address takes effect in the same cycle, after the commit.
- Direct 10 -> 01 transition: the commit happens first. The read in the following cycle returns the newly written value.
- Every field output is a combinational slice of the register file. There is no extra output register.

## Timing
- Reset: all registers 0, addr = 0, addr_valid = 0, hold_data = 0, data_out = 0, data_oe = 0, env_restart = 0, all field outputs 0. A pending write is discarded.
- Latch: the bus latch mode is present at edge N. The sample is taken at N and addr updates at N+1.
- Write: the last write-mode bus cycle is at edge N and the bus leaves write mode at edge N+1. The register and field output update at N+2. env_restart is high during the cycle following N+2.
- Read: the bus read mode is present at edge N. data_oe and data_out are valid after N+2 and drop 2 edges after the bus leaves read mode.
- Back-to-back write, inactive, write to the same register: the last commit wins. There is no minimum gap beyond one non-write sample between writes.

## Configuration
- BUS_READBACK_EN defined: the read path is present as described.
- BUS_READBACK_EN not defined: the read decode and output mux are removed. data_out is tied to 0 and data_oe to 0. Write and latch behaviour is unchanged.

## Test plan
- Reset, then read R7 with no latch -> data_oe = 0, data_out = 0. All field outputs = 0.
- Latch 0x06, write 0xFF, go inactive -> noise_period = 5'h1F two cycles after bus inactive. Read R6 -> 0x1F (upper bits masked).
- Latch 0x16 with CHIP_ADDR = 0, then write 0x55 -> no register changes, addr_valid = 0, read -> data_oe = 0.
- Latch 0x00, write 0x34. Latch 0x01, write 0xAB -> tone_period_a = 12'hB34.
- Latch 0x0D, write 0x0A twice with an inactive cycle between -> env_shape = 4'hA and two separate one-cycle env_restart pulses.
- Write 0x12 to R8, then assert reset during a second write of 0x1F to R8 -> after reset amp_a = 0 and no commit occurs once the bus goes inactive.

Source files
------------

// File: rtl/psg_bus_decoder.sv
// AY-3-8910 compatible host bus decoder and 16-entry register file.
// Define BUS_READBACK_EN to build the register read path; otherwise data_out/data_oe tie to 0.
module psg_bus_decoder #(
   parameter logic [3:0] CHIP_ADDR = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bdir,
   input  logic        bc1,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [11:0] tone_period_a,
   output logic [11:0] tone_period_b,
   output logic [11:0] tone_period_c,
   output logic [4:0]  noise_period,
   output logic [7:0]  mixer,
   output logic [4:0]  amp_a,
   output logic [4:0]  amp_b,
   output logic [4:0]  amp_c,
   output logic [15:0] env_period,
   output logic [3:0]  env_shape,
   output logic        env_restart,
   output logic [7:0]  io_a,
   output logic [7:0]  io_b
);

   typedef enum logic [1:0] {
      ModeIdle  = 2'b00,
      ModeRead  = 2'b01,
      ModeWrite = 2'b10,
      ModeLatch = 2'b11
   } mode_e;

   mode_e       mode_q;
   logic [7:0]  din_q;
   logic [3:0]  addr_q;
   logic        addr_valid_q;
   logic [7:0]  hold_q;
   logic        wr_pend_q;
   logic        env_restart_q;
   logic [7:0]  regs_q [16];
   logic        commit;

   function automatic logic [7:0] wmask(input logic [3:0] a);
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13: wmask = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: wmask = 8'h1F;
         default:                 wmask = 8'hFF;
      endcase
   endfunction

   // Commit fires on the first sampled non-write cycle after a write cycle.
   assign commit = wr_pend_q && (mode_q != ModeWrite) && addr_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q        <= ModeIdle;
         din_q         <= '0;
         addr_q        <= '0;
         addr_valid_q  <= 1'b0;
         hold_q        <= '0;
         wr_pend_q     <= 1'b0;
         env_restart_q <= 1'b0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         mode_q        <= mode_e'({bdir, bc1});
         din_q         <= data_in;
         wr_pend_q     <= (mode_q == ModeWrite);
         env_restart_q <= 1'b0;
         if (mode_q == ModeWrite) hold_q <= din_q;
         // Commit uses the current addr_q, so a 10->11 transition writes the old address.
         if (commit) begin
            regs_q[addr_q] <= hold_q & wmask(addr_q);
            env_restart_q  <= (addr_q == 4'd13);
         end
         if (mode_q == ModeLatch) begin
            if (din_q[7:4] == CHIP_ADDR) begin
               addr_q       <= din_q[3:0];
               addr_valid_q <= 1'b1;
            end else begin
               addr_valid_q <= 1'b0;
            end
         end
      end
   end

`ifdef BUS_READBACK_EN
   logic       rd_q;
   logic       data_oe_q;
   logic [7:0] data_out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q       <= 1'b0;
         data_oe_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         rd_q       <= (mode_q == ModeRead);
         data_oe_q  <= rd_q && addr_valid_q;
         data_out_q <= (rd_q && addr_valid_q) ? regs_q[addr_q] : 8'h00;
      end
   end

   assign data_oe  = data_oe_q;
   assign data_out = data_out_q;
`else
   assign data_oe  = 1'b0;
   assign data_out = 8'h00;
`endif

   assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
   assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
   assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
   assign noise_period  = regs_q[6][4:0];
   assign mixer         = regs_q[7];
   assign amp_a         = regs_q[8][4:0];
   assign amp_b         = regs_q[9][4:0];
   assign amp_c         = regs_q[10][4:0];
   assign env_period    = {regs_q[12], regs_q[11]};
   assign env_shape     = regs_q[13][3:0];
   assign env_restart   = env_restart_q;
   assign io_a          = regs_q[14];
   assign io_b          = regs_q[15];

   // Masked-off bits are always stored as zero.
   logic unused_bits;
   assign unused_bits = ^{regs_q[1][7:4], regs_q[3][7:4], regs_q[5][7:4], regs_q[13][7:4],
                          regs_q[6][7:5], regs_q[8][7:5], regs_q[9][7:5], regs_q[10][7:5]};

endmodule

// File: tb/tb_psg_bus_decoder.sv
// Directed self-checking bench for psg_bus_decoder.
module tb_psg_bus_decoder;

`ifdef BUS_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        bdir, bc1;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [11:0] tone_period_a, tone_period_b, tone_period_c;
   logic [4:0]  noise_period;
   logic [7:0]  mixer;
   logic [4:0]  amp_a, amp_b, amp_c;
   logic [15:0] env_period;
   logic [3:0]  env_shape;
   logic        env_restart;
   logic [7:0]  io_a, io_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   psg_bus_decoder #(.CHIP_ADDR(4'h0)) dut (
      .clk(clk), .reset(reset), .bdir(bdir), .bc1(bc1), .data_in(data_in),
      .data_out(data_out), .data_oe(data_oe),
      .tone_period_a(tone_period_a), .tone_period_b(tone_period_b),
      .tone_period_c(tone_period_c), .noise_period(noise_period), .mixer(mixer),
      .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c), .env_period(env_period),
      .env_shape(env_shape), .env_restart(env_restart), .io_a(io_a), .io_b(io_b)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change away from the rising edge; each step spans exactly one rising edge.
   task automatic step(input logic b, input logic c, input logic [7:0] d);
      bdir = b; bc1 = c; data_in = d;
      @(negedge clk);
   endtask

   task automatic latch(input logic [7:0] a); step(1'b1, 1'b1, a); endtask
   task automatic wr(input logic [7:0] d);    step(1'b1, 1'b0, d); endtask
   task automatic rd();                       step(1'b0, 1'b1, 8'h00); endtask
   task automatic idle();                     step(1'b0, 1'b0, 8'h00); endtask

   initial begin
      reset = 1'b1;
      repeat (3) idle();
      reset = 1'b0;
      idle();
      check("rst_tone_a", 16'(tone_period_a), 16'h000);
      check("rst_tone_c", 16'(tone_period_c), 16'h000);
      check("rst_noise", 16'(noise_period), 16'h00);
      check("rst_mixer", 16'(mixer), 16'h00);
      check("rst_amp_a", 16'(amp_a), 16'h00);
      check("rst_env_period", env_period, 16'h0000);
      check("rst_env_shape", 16'(env_shape), 16'h0);
      check("rst_env_restart", 16'(env_restart), 16'h0);
      check("rst_io_a", 16'(io_a), 16'h00);
      check("rst_data_oe", 16'(data_oe), 16'h0);

      // Read R7 before any latch: address not valid
      repeat (3) rd();
      check("nolatch_oe", 16'(data_oe), 16'h0);
      check("nolatch_dout", 16'(data_out), 16'h00);
      repeat (3) idle();

      // R6 write of 0xFF lands masked two edges after the bus goes inactive
      latch(8'h06);
      wr(8'hFF);
      idle();
      check("noise_early", 16'(noise_period), 16'h00);
      idle();
      check("noise_ff", 16'(noise_period), 16'h1F);
      rd();
      rd();
      check("rd_oe_early", 16'(data_oe), 16'h0);
      rd();
      check("rd_r6_oe", 16'(data_oe), 16'(RB));
      check("rd_r6_dout", 16'(data_out), RB ? 16'h1F : 16'h00);
      idle();
      idle();
      check("rd_oe_hold", 16'(data_oe), 16'(RB));
      idle();
      check("rd_oe_drop", 16'(data_oe), 16'h0);

      // Foreign chip select invalidates the address; write is discarded
      latch(8'h16);
      wr(8'h55);
      idle();
      idle();
      check("foreign_noise", 16'(noise_period), 16'h1F);
      repeat (3) rd();
      check("foreign_oe", 16'(data_oe), 16'h0);
      repeat (3) idle();

      // Direct write->latch transitions; R1 keeps its low nibble only
      latch(8'h00);
      wr(8'h34);
      latch(8'h01);
      wr(8'hAB);
      idle();
      idle();
      check("tone_a", 16'(tone_period_a), 16'h0B34);
      check("tone_b", 16'(tone_period_b), 16'h000);

      // Direct write->read: read returns the freshly committed value
      latch(8'h07);
      wr(8'hA5);
      repeat (3) rd();
      check("mixer", 16'(mixer), 16'h00A5);
      check("wr_rd_oe", 16'(data_oe), 16'(RB));
      check("wr_rd_dout", 16'(data_out), RB ? 16'h00A5 : 16'h0000);
      repeat (3) idle();

      latch(8'h0B);
      wr(8'h78);
      latch(8'h0C);
      wr(8'h56);
      latch(8'h0F);
      wr(8'hC3);
      idle();
      idle();
      check("env_period", env_period, 16'h5678);
      check("io_b", 16'(io_b), 16'h00C3);

      // R13 written twice with one idle sample between: two separate pulses
      latch(8'h0D);
      wr(8'h0A);
      idle();
      check("restart_pre", 16'(env_restart), 16'h0);
      wr(8'h0A);
      check("restart_1", 16'(env_restart), 16'h1);
      idle();
      check("restart_gap", 16'(env_restart), 16'h0);
      idle();
      check("restart_2", 16'(env_restart), 16'h1);
      idle();
      check("restart_end", 16'(env_restart), 16'h0);
      check("env_shape", 16'(env_shape), 16'h000A);

      // Reset in the middle of a write discards it
      latch(8'h08);
      wr(8'h12);
      idle();
      idle();
      check("amp_a_12", 16'(amp_a), 16'h0012);
      wr(8'h1F);
      reset = 1'b1;
      wr(8'h1F);
      wr(8'h1F);
      reset = 1'b0;
      idle();
      check("amp_a_after_rst", 16'(amp_a), 16'h0000);
      repeat (3) idle();
      check("amp_a_no_commit", 16'(amp_a), 16'h0000);
      check("noise_after_rst", 16'(noise_period), 16'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
